// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with per-channel tick strobe.
// Divisor writes are staged and applied only at a period boundary, a clear, or while disabled.
module clk_div_prog #(
  parameter int unsigned CH          = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned DEFAULT_DIV = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    en,
  input  logic [CH-1:0]    clr,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_data,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    div_pend
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0] wr_val;

  // Divisors below 2 cannot form a two-phase clock.
  assign wr_val = (div_data < MinDiv) ? MinDiv : div_data;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit, wrap, apply;

    // Selects at or above CH never match any channel index.
    assign wr_hit = div_wr && (int'(div_sel) == i);
    assign wrap   = en[i] && (cnt_q == div_q - One);

    always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      tick_d     = 1'b0;
      apply      = 1'b0;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;

      if (clr[i]) begin
        apply = pend_q;
        cnt_d = '0;
      end else if (!en[i]) begin
        apply = pend_q;
      end else if (wrap) begin
        apply  = pend_q;
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + One;
      end

      if (apply) div_d = pend_val_q;
      // A smaller divisor applied while held can leave the count out of range.
      if (cnt_d >= div_d) cnt_d = '0;

      clk_d = (cnt_d >= (div_d >> 1));

      if (wr_hit) begin
        pend_d     = 1'b1;
        pend_val_d = wr_val;
      end else if (apply) begin
        pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q      <= '0;
        div_q      <= DefDiv;
        pend_val_q <= DefDiv;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_q      <= div_d;
        pend_val_q <= pend_val_d;
        pend_q     <= pend_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_out[i]  = clk_q;
    assign tick[i]     = tick_q;
    assign div_pend[i] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog, run with a shortened default divisor of 10.
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  en, clr, clk_out, tick, div_pend;
  logic        div_wr;
  logic [1:0]  div_sel;
  logic [31:0] div_data;

  logic [2:0]  en2, clr2, clk_out2, tick2, div_pend2;
  logic        div_wr2;
  logic [1:0]  div_sel2;
  logic [31:0] div_data2;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.CH(4), .CNT_W(32), .SEL_W(2), .DEFAULT_DIV(10)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .div_wr(div_wr), .div_sel(div_sel),
    .div_data(div_data), .clk_out(clk_out), .tick(tick), .div_pend(div_pend)
  );

  clk_div_prog #(.CH(3), .CNT_W(32), .SEL_W(2), .DEFAULT_DIV(10)) dut3 (
    .clk(clk), .reset(reset), .en(en2), .clr(clr2), .div_wr(div_wr2), .div_sel(div_sel2),
    .div_data(div_data2), .clk_out(clk_out2), .tick(tick2), .div_pend(div_pend2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_div(input int ch, input logic [31:0] val);
    en[ch]   = 1'b0;
    div_wr   = 1'b1;
    div_sel  = 2'(ch);
    div_data = val;
    step();
    div_wr  = 1'b0;
    clr[ch] = 1'b1;
    step();
    clr[ch] = 1'b0;
    checks++;
    if ({div_pend[ch], clk_out[ch], tick[ch]} !== 3'b000) begin
      errors++;
      $display("FAIL load_div ch%0d pend/clk/tick got %b exp 000", ch,
               {div_pend[ch], clk_out[ch], tick[ch]});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = '0; clr = '0; div_wr = 0; div_sel = '0; div_data = '0;
    en2 = '0; clr2 = '0; div_wr2 = 0; div_sel2 = '0; div_data2 = '0;
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({clk_out, tick, div_pend} !== 12'h000) begin
      errors++;
      $display("FAIL reset_initial got %h exp 000", {clk_out, tick, div_pend});
    end
    step();
    reset = 1'b1;
    en[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (tick[0] !== (k == 10) || clk_out[0] !== (k >= 5 && k <= 9)) begin
        errors++;
        $display("FAIL first_period k=%0d tick/clk got %b%b exp %b%b", k, tick[0], clk_out[0],
                 k == 10, k >= 5 && k <= 9);
      end
    end
    en[1] = 1'b1; div_wr = 1'b1; div_sel = 2'd1; div_data = 32'd7;
    step();
    div_wr = 1'b0;
    repeat (4) step();
    checks++;
    if (clk_out[0] !== 1'b1 || div_pend[1] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset clk0/pend1 got %b%b exp 11", clk_out[0], div_pend[1]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick, div_pend} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset got %h exp 000", {clk_out, tick, div_pend});
    end
    en = '0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_duty();
    load_div(1, 32'd5);
    en[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (clk_out[1] !== ((k % 5) >= 2) || tick[1] !== ((k % 5) == 0)) begin
        errors++;
        $display("FAIL duty_d5 k=%0d clk/tick got %b%b", k, clk_out[1], tick[1]);
      end
    end
    load_div(1, 32'd1);
    en[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (clk_out[1] !== ((k % 2) == 1) || tick[1] !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL duty_clamp1 k=%0d clk/tick got %b%b", k, clk_out[1], tick[1]);
      end
    end
    load_div(1, 32'd5);
    load_div(1, 32'd0);
    en[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (clk_out[1] !== ((k % 2) == 1) || tick[1] !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL duty_clamp0 k=%0d clk/tick got %b%b", k, clk_out[1], tick[1]);
      end
    end
    en[1] = 1'b0;
  endtask

  task automatic test_midperiod();
    load_div(2, 32'd8);
    en[2] = 1'b1;
    repeat (3) step();
    div_wr = 1'b1; div_sel = 2'd2; div_data = 32'd4;
    step();
    div_wr = 1'b0;
    checks++;
    if (div_pend[2] !== 1'b1 || clk_out[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_write pend/clk got %b%b exp 11", div_pend[2], clk_out[2]);
    end
    for (int k = 5; k <= 8; k++) begin
      step();
      checks++;
      if (tick[2] !== (k == 8) || div_pend[2] !== (k < 8) || clk_out[2] !== (k < 8)) begin
        errors++;
        $display("FAIL mid_finish k=%0d tick/pend/clk got %b%b%b", k, tick[2], div_pend[2],
                 clk_out[2]);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (tick[2] !== ((k % 4) == 0) || clk_out[2] !== ((k % 4) >= 2)) begin
        errors++;
        $display("FAIL mid_new_d4 k=%0d tick/clk got %b%b", k, tick[2], clk_out[2]);
      end
    end
    en[2] = 1'b0;
  endtask

  task automatic test_enable_collision();
    load_div(0, 32'd10);
    en[0] = 1'b1;
    repeat (6) step();
    en[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (clk_out[0] !== 1'b1 || tick[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold k=%0d clk/tick got %b%b exp 10", k, clk_out[0], tick[0]);
      end
    end
    en[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (tick[0] !== (k == 4)) begin
        errors++;
        $display("FAIL resume k=%0d tick got %b exp %b", k, tick[0], k == 4);
      end
    end
    repeat (6) step();
    en[0] = 1'b0;
    div_wr = 1'b1; div_sel = 2'd0; div_data = 32'd4;
    step();
    div_wr = 1'b0;
    checks++;
    if (div_pend[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL dis_write pend/clk got %b%b exp 11", div_pend[0], clk_out[0]);
    end
    step();
    checks++;
    if (div_pend[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL dis_apply pend/clk got %b%b exp 00", div_pend[0], clk_out[0]);
    end
    en[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (tick[0] !== (k == 4) || clk_out[0] !== (k == 2 || k == 3)) begin
        errors++;
        $display("FAIL forced_zero k=%0d tick/clk got %b%b", k, tick[0], clk_out[0]);
      end
    end
    div_wr = 1'b1; div_data = 32'd6;
    step();
    div_wr = 1'b0;
    repeat (2) step();
    div_wr = 1'b1; div_data = 32'd8;
    step();
    div_wr = 1'b0;
    checks++;
    if (tick[0] !== 1'b1 || div_pend[0] !== 1'b1) begin
      errors++;
      $display("FAIL collide_edge tick/pend got %b%b exp 11", tick[0], div_pend[0]);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (tick[0] !== (k == 6) || div_pend[0] !== (k < 6) || clk_out[0] !== (k >= 3 && k < 6))
      begin
        errors++;
        $display("FAIL collide_d6 k=%0d tick/pend/clk got %b%b%b", k, tick[0], div_pend[0],
                 clk_out[0]);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (tick[0] !== (k == 8)) begin
        errors++;
        $display("FAIL collide_d8 k=%0d tick got %b exp %b", k, tick[0], k == 8);
      end
    end
    en[0] = 1'b0;
  endtask

  task automatic test_phase_align();
    load_div(0, 32'd6);
    load_div(3, 32'd12);
    en[0] = 1'b1;
    repeat (2) step();
    en[3] = 1'b1;
    repeat (5) step();
    clr = 4'b1001;
    step();
    clr = '0;
    checks++;
    if ({clk_out[3], clk_out[0], tick[3], tick[0]} !== 4'b0000) begin
      errors++;
      $display("FAIL align_clr clk3/clk0/tick3/tick0 got %b exp 0000",
               {clk_out[3], clk_out[0], tick[3], tick[0]});
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (tick[0] !== ((k % 6) == 0) || tick[3] !== (k == 12) ||
          clk_out[3] !== (k >= 6 && k < 12)) begin
        errors++;
        $display("FAIL align k=%0d tick0/tick3/clk3 got %b%b%b", k, tick[0], tick[3],
                 clk_out[3]);
      end
    end
    en = '0;
  endtask

  task automatic test_bad_select();
    div_wr2 = 1'b1; div_sel2 = 2'd3; div_data2 = 32'd4;
    step();
    div_wr2 = 1'b0;
    checks++;
    if (div_pend2 !== 3'b000) begin
      errors++;
      $display("FAIL bad_sel_pend got %b exp 000", div_pend2);
    end
    en2 = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (tick2 !== ((k == 10) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL bad_sel_period k=%0d tick got %b", k, tick2);
      end
    end
    en2 = '0;
    div_wr2 = 1'b1; div_sel2 = 2'd2;
    step();
    div_wr2 = 1'b0;
    checks++;
    if (div_pend2 !== 3'b100) begin
      errors++;
      $display("FAIL good_sel_pend got %b exp 100", div_pend2);
    end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_midperiod();
    test_enable_collision();
    test_phase_align();
    test_bad_select();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
